// File: rtl/load_scoreboard_pkg.sv
// Shared types and defaults for the long-latency load scoreboard.
//   SB_* localparams : default parameter values for load_scoreboard
//   creg_addr_t      : architectural register address
//   sb_idx_t         : scoreboard entry index
//   sb_entry_t       : one scoreboard entry {valid, zombie, dst}
package load_scoreboard_pkg;

  localparam int unsigned SB_NUM_SRC = 2;
  localparam int unsigned SB_AW      = 5;
  localparam int unsigned SB_DEPTH   = 4;
  localparam int unsigned SB_CW      = 32;
  localparam int unsigned SB_IW      = $clog2(SB_DEPTH);

  typedef logic u1;
  localparam u1 ON  = 1'b1;
  localparam u1 OFF = 1'b0;

  typedef logic [SB_AW-1:0] creg_addr_t;
  typedef logic [SB_IW-1:0] sb_idx_t;

  // FREE: valid=0; LIVE: valid=1,zombie=0; ZOMBIE: valid=1,zombie=1
  typedef struct packed {
    logic       valid;
    logic       zombie;
    creg_addr_t dst;
  } sb_entry_t;

endpackage

// File: rtl/load_scoreboard_sb_free_pick.sv
// Lowest-index free-entry priority encoder.
//   free_i  : one bit per entry, 1 = entry is FREE
//   idx_o   : index of the lowest set bit of free_i (0 when none)
//   found_o : at least one entry is FREE
module sb_free_pick #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] free_i,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (free_i[e]) begin
        idx_o   = IW'(e);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_scoreboard.sv
// Scoreboard of in-flight long-latency register writes beside decode/issue.
// Stalls decode on RAW/WAW against LIVE entries or when no entry is free,
// allocates entries for long-latency writers, frees them on writeback and
// turns LIVE entries into ZOMBIEs on flush.
//   clk, reset              : clock, synchronous active-high reset
//   src_valid/src_addr      : decode source operands (NUM_SRC x AW)
//   iss_valid/iss_long/dst  : decode instruction issue request
//   cmp_valid/cmp_idx       : writeback completion of a tracked op
//   flush                   : pipeline flush
//   stall, stall_raw/waw/full : stall and cause breakdown (combinational)
//   alloc_valid/alloc_idx   : entry allocated this cycle (combinational)
//   busy_count              : occupied entries including zombies
//   stall_cycles            : saturating stall-cycle counter (registered)
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SRC = SB_NUM_SRC,
  parameter int unsigned AW      = SB_AW,
  parameter int unsigned DEPTH   = SB_DEPTH,
  parameter int unsigned CW      = SB_CW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*AW-1:0]    src_addr,
  input  logic                     iss_valid,
  input  logic                     iss_long,
  input  logic [AW-1:0]            iss_dst,
  input  logic                     cmp_valid,
  input  logic [$clog2(DEPTH)-1:0] cmp_idx,
  input  logic                     flush,
  output logic                     stall,
  output logic                     stall_raw,
  output logic                     stall_waw,
  output logic                     stall_full,
  output logic                     alloc_valid,
  output logic [$clog2(DEPTH)-1:0] alloc_idx,
  output logic [$clog2(DEPTH):0]   busy_count,
  output logic [CW-1:0]            stall_cycles
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned CNTW = IW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] zombie_q, zombie_d;
  logic [AW-1:0]    dst_q [DEPTH];
  logic [AW-1:0]    dst_d [DEPTH];
  logic [CW-1:0]    stall_cycles_q, stall_cycles_d;

  logic [DEPTH-1:0] hazard_ok;
  logic             raw_hit, waw_hit, full_hit, stall_any, alloc_go;
  logic             iss_writes;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;

  // Entries able to cause a hazard: LIVE and not completing this cycle.
  always_comb begin
    hazard_ok = '0;
    for (int e = 0; e < DEPTH; e++) begin
      hazard_ok[e] = valid_q[e] & ~zombie_q[e] & ~(cmp_valid && (cmp_idx == IW'(e)));
    end
  end

  assign iss_writes = iss_valid && (iss_dst != '0);

  // RAW against any used source, WAW against the destination.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && (src_addr[i*AW +: AW] != '0) && hazard_ok[e] &&
            (src_addr[i*AW +: AW] == dst_q[e])) begin
          raw_hit = 1'b1;
        end
      end
      if (iss_writes && hazard_ok[e] && (iss_dst == dst_q[e])) begin
        waw_hit = 1'b1;
      end
    end
  end

  sb_free_pick #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_free_pick (
    .free_i  (~valid_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Occupancy is the registered state; a slot freed this cycle is not reusable yet.
  assign full_hit  = iss_writes && iss_long && !pick_found;
  assign stall_any = raw_hit | waw_hit | full_hit;
  assign alloc_go  = iss_writes && iss_long && !stall_any && !flush;

  assign stall       = stall_any & ~flush;
  assign stall_raw   = raw_hit  & ~flush;
  assign stall_waw   = waw_hit  & ~flush;
  assign stall_full  = full_hit & ~flush;
  assign alloc_valid = alloc_go;
  assign alloc_idx   = alloc_go ? pick_idx : '0;

  // Entry update: completion frees, flush zombifies, allocation claims a FREE slot.
  always_comb begin
    valid_d  = valid_q;
    zombie_d = zombie_q;
    dst_d    = dst_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (cmp_valid && (cmp_idx == IW'(e))) begin
        valid_d[e]  = 1'b0;
        zombie_d[e] = 1'b0;
      end else if (flush && valid_q[e]) begin
        zombie_d[e] = 1'b1;
      end
      if (alloc_go && (pick_idx == IW'(e))) begin
        valid_d[e]  = 1'b1;
        zombie_d[e] = 1'b0;
        dst_d[e]    = iss_dst;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      zombie_q       <= '0;
      stall_cycles_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        dst_q[e] <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      zombie_q       <= zombie_d;
      stall_cycles_q <= stall_cycles_d;
      for (int e = 0; e < DEPTH; e++) begin
        dst_q[e] <= dst_d[e];
      end
    end
  end

  // Occupied entries, zombies included.
  always_comb begin
    busy_count = '0;
    for (int e = 0; e < DEPTH; e++) begin
      busy_count = busy_count + CNTW'(valid_q[e]);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed-vector bench for load_scoreboard (default DUT plus a CW=4 copy
// driven by the same stimulus for counter saturation).
module tb_load_scoreboard;

  localparam int unsigned AW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src_valid;
  logic [9:0]  src_addr;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_dst;
  logic        cmp_valid;
  logic [1:0]  cmp_idx;
  logic        flush;

  logic        stall, stall_raw, stall_waw, stall_full, alloc_valid;
  logic [1:0]  alloc_idx;
  logic [2:0]  busy_count;
  logic [31:0] stall_cycles;

  logic        s_stall, s_raw, s_waw, s_full, s_alloc_valid;
  logic [1:0]  s_alloc_idx;
  logic [2:0]  s_busy;
  logic [3:0]  s_stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_scoreboard u_dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_addr(src_addr),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_dst(iss_dst),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .flush(flush),
    .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw),
    .stall_full(stall_full), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .busy_count(busy_count), .stall_cycles(stall_cycles)
  );

  load_scoreboard #(.CW(4)) u_dut_small (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_addr(src_addr),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_dst(iss_dst),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .flush(flush),
    .stall(s_stall), .stall_raw(s_raw), .stall_waw(s_waw),
    .stall_full(s_full), .alloc_valid(s_alloc_valid), .alloc_idx(s_alloc_idx),
    .busy_count(s_busy), .stall_cycles(s_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset     = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    iss_valid = 1'b0;
    iss_long  = 1'b0;
    iss_dst   = '0;
    cmp_valid = 1'b0;
    cmp_idx   = '0;
    flush     = 1'b0;
  endtask

  // Advance one clock edge; inputs/outputs settle #1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] a);
    src_valid[i]          = 1'b1;
    src_addr[i*AW +: AW]  = a;
  endtask

  task automatic issue_long(input logic [4:0] d);
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_dst   = d;
  endtask

  task automatic complete(input logic [1:0] idx);
    cmp_valid = 1'b1;
    cmp_idx   = idx;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_alloc_valid", 32'(alloc_valid), 0);
    check("rst_busy", 32'(busy_count), 0);
    check("rst_stall_cycles", stall_cycles, 0);

    // 1: load x5, RAW stall, WB bypass
    issue_long(5'd5); #1;
    check("t1_alloc_valid", 32'(alloc_valid), 1);
    check("t1_alloc_idx", 32'(alloc_idx), 0);
    check("t1_alloc_stall", 32'(stall), 0);
    cyc(); idle(); set_src(0, 5'd5); #1;
    check("t1_raw_stall", 32'(stall), 1);
    check("t1_raw_cause", 32'(stall_raw), 1);
    complete(2'd0); #1;
    check("t1_bypass_stall", 32'(stall), 0);
    cyc(); idle(); set_src(1, 5'd5); #1;
    check("t1_freed_busy", 32'(busy_count), 0);
    check("t1_freed_stall", 32'(stall), 0);

    // 2: fill table, full stall, freed slot reused next cycle
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); issue_long(5'(k + 1)); #1;
      check("t2_fill_idx", 32'(alloc_idx), 32'(k));
    end
    cyc(); idle(); issue_long(5'd6); #1;
    check("t2_full", 32'(stall_full), 1);
    check("t2_full_stall", 32'(stall), 1);
    check("t2_full_noalloc", 32'(alloc_valid), 0);
    check("t2_busy4", 32'(busy_count), 4);
    complete(2'd2); #1;
    check("t2_full_same_cycle", 32'(stall_full), 1);
    cyc(); idle(); issue_long(5'd6); #1;
    check("t2_realloc_valid", 32'(alloc_valid), 1);
    check("t2_realloc_idx", 32'(alloc_idx), 2);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); complete(2'(k));
    end
    cyc(); idle(); #1;
    check("t2_drained", 32'(busy_count), 0);

    // 3: WAW on ALU writer, x0 never hazards or allocates
    issue_long(5'd7); #1;
    check("t3_alloc_idx", 32'(alloc_idx), 0);
    cyc(); idle();
    iss_valid = 1'b1; iss_dst = 5'd7; #1;
    check("t3_waw", 32'(stall_waw), 1);
    check("t3_waw_stall", 32'(stall), 1);
    idle(); issue_long(5'd0); set_src(0, 5'd0); #1;
    check("t3_x0_alloc", 32'(alloc_valid), 0);
    check("t3_x0_stall", 32'(stall), 0);
    complete(2'd0);
    cyc(); idle(); #1;
    check("t3_drained", 32'(busy_count), 0);

    // 4: flush turns LIVE into ZOMBIE
    issue_long(5'd3);
    cyc(); idle(); issue_long(5'd4); #1;
    check("t4_alloc_idx1", 32'(alloc_idx), 1);
    cyc(); idle(); flush = 1'b1;
    cyc(); idle(); set_src(0, 5'd3); set_src(1, 5'd4); #1;
    check("t4_zombie_nostall", 32'(stall), 0);
    check("t4_zombie_busy", 32'(busy_count), 2);
    idle(); complete(2'd0);
    cyc(); idle(); complete(2'd1);
    cyc(); idle(); #1;
    check("t4_drained", 32'(busy_count), 0);

    // 5: flush with issue and completion in the same cycle
    issue_long(5'd8);
    cyc(); idle(); issue_long(5'd10);
    cyc(); idle();
    flush = 1'b1; issue_long(5'd11); complete(2'd1); set_src(0, 5'd8); #1;
    check("t5_flush_alloc", 32'(alloc_valid), 0);
    check("t5_flush_stall", 32'(stall), 0);
    check("t5_flush_raw", 32'(stall_raw), 0);
    cyc(); idle(); #1;
    check("t5_busy1", 32'(busy_count), 1);
    issue_long(5'd12); set_src(0, 5'd8); #1;
    check("t5_reuse_idx1", 32'(alloc_idx), 1);
    check("t5_zombie_src", 32'(stall), 0);
    cyc(); idle(); complete(2'd0);
    cyc(); idle(); complete(2'd1);
    cyc(); idle(); #1;
    check("t5_drained", 32'(busy_count), 0);

    // 6: stall counter, saturation, reset mid-stall
    reset = 1'b1;
    cyc(); idle(); #1;
    check("t6_cnt_cleared", stall_cycles, 0);
    check("t6_small_cleared", 32'(s_stall_cycles), 0);
    issue_long(5'd5);
    cyc(); idle(); set_src(0, 5'd5);
    for (int k = 0; k < 10; k++) cyc();
    check("t6_cnt10", stall_cycles, 10);
    for (int k = 0; k < 10; k++) cyc();
    check("t6_cnt20", stall_cycles, 20);
    check("t6_small_sat", 32'(s_stall_cycles), 15);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("t6_rst_cnt", stall_cycles, 0);
    check("t6_rst_small", 32'(s_stall_cycles), 0);
    check("t6_rst_busy", 32'(busy_count), 0);
    check("t6_rst_stall", 32'(stall), 0);
    idle(); complete(2'd0);
    cyc(); idle(); #1;
    check("t6_stale_cmp", 32'(busy_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
